vector_stream_alu: RTL
======================

Name: vector_stream_alu

Overview:
- Lane-parallel, multi-cycle successor to the single-shot element ALU.
- Processes a vector of up to N elements, LANES elements per clock beat, under a start/busy/done handshake.
- Writes results into an internal result register file with length tracking and zero-masking of elements at or beyond the result length.
- Sits between the vector register file and the host-command decoder of the accelerator.

Parameters:
- BITS, 8: element width, two's complement.
- N, 64: maximum vector length. Must be a multiple of LANES.
- LANES, 8: elements computed per beat. Power of two, 1..N.
- MULT_SHIFT, 0: right shift applied to the full product before truncation. Range 0..BITS.
- LEN_W, $clog2(N+1): width of the length fields.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- A  in  BITS x N  operand vector. Held stable by the source while busy.
- A_len  in  LEN_W  valid length of A.
- B  in  BITS x N  operand vector. Held stable while busy.
- B_len  in  LEN_W  valid length of B.
- scalar  in  BITS  scalar operand; captured at start.
- op_sel  in  3  operation code; captured at start.
- scalar_sel  in  1  1 = use scalar in place of every B element; captured at start.
- start  in  1  request. Accepted only in IDLE.
- busy  out  1  high in CLEAR and RUN.
- done  out  1  one-cycle pulse when S and S_len are final.
- S  out  BITS x N  result register file.
- S_len  out  LEN_W  result length register.

Behaviour:
- Reset: all outputs 0 (S, S_len, busy, done); state IDLE; beat counter 0. Reset mid-operation aborts immediately, with no partial completion.
- States: IDLE -> CLEAR -> RUN -> DONE -> IDLE.
- IDLE: start=1 captures op_sel, scalar, scalar_sel and the computed length L. Next state is CLEAR.
  - L = A_len if scalar_sel=1, otherwise max(A_len, B_len).
  - L is saturated to N.
- CLEAR (1 cycle): all N elements of S set to 0; S_len <= L; beat counter <= 0. Next state is RUN if L>0, otherwise DONE.
- RUN: beat k writes S[k*LANES+j] for j = 0..LANES-1.
  - Elements with index >= L are written 0.
  - Run lasts ceil(L/LANES) beats; the last beat goes to DONE.
  - Elements beyond the last beat keep their CLEAR value of 0.
- DONE (1 cycle): done=1, busy=0, then IDLE.
- Start-to-done latency: 2 + ceil(L/LANES) cycles.
- start while not in IDLE is ignored; it is neither queued nor an error.
- The second operand per element is the captured scalar when scalar_sel=1, else B[i]. B_len is ignored when scalar_sel=1.
- op_sel encoding:
  - 000 add; 001 sub (A-B).
  - 010 mult: signed BITS x BITS product kept to 2*BITS bits; result = product[MULT_SHIFT+BITS-1 : MULT_SHIFT].
  - 011 cmp: +1 if A>B, 0 if A==B, all-ones (-1) if A<B. This is a true signed comparison and is correct under overflow.
  - 100 and; 101 or; 110 xor; 111 not A (second operand ignored).
- Default arithmetic wraps modulo 2^BITS.
- S holds its last result until the next accepted start.
- No combinational path from any input to S or S_len.

Optional Feature:
- Macro: VECTOR_STREAM_ALU_SATURATE_EN.
- Defined: add, sub and mult clamp to the signed range [-2^(BITS-1), 2^(BITS-1)-1]. For mult, the clamp is applied after MULT_SHIFT. Logic ops and cmp are unchanged.
- Undefined: wrap-around as above, and no saturation logic is synthesised.

Test Plan:
- Reset then idle: assert rst for 2 cycles -> S all 0, S_len=0, busy=0, done=0; start is ignored while rst=1.
- Vector add, defaults: A[i]=i, B[i]=2i, A_len=20, B_len=12, op=000, scalar_sel=0 -> done at cycle 2+3=5 after start; S[i]=3i for i<20; S[20..63]=0; S_len=20.
- Scalar mult with shift (MULT_SHIFT=2): A[i]=-8 for all i, scalar=6, A_len=8, op=010, scalar_sel=1 -> S[0..7]=0xF4 (-48>>2=-12); S_len=8; done latency 3.
- Signed compare at overflow: A[0]=127, B[0]=-128, A[1]=-128, B[1]=127, A[2]=B[2]=5, lengths 3, op=011 -> S[0]=0x01, S[1]=0xFF, S[2]=0x00.
- Boundaries: L=0 -> done 2 cycles after start, S all 0, S_len=0; A_len=N -> 8 beats, all 64 elements written; start pulsed while busy -> ignored; rst asserted mid-RUN -> all outputs 0, no done pulse.
- With VECTOR_STREAM_ALU_SATURATE_EN: A[0]=100, B[0]=100, op=000 -> S[0]=127; op=001, A[0]=-100, B[0]=100 -> S[0]=-128. Without the macro, the same stimuli -> 0xC8 and 0x38.

Source files
------------

// File: rtl/vector_stream_alu_if.sv
// Operand/result bundle between the vector register file, the host-command decoder and vector_stream_alu.
// The master modport is the requester side; the slave modport is the ALU side.
interface vector_stream_alu_if #(
  parameter int BITS  = 8,
  parameter int N     = 64,
  parameter int LEN_W = $clog2(N + 1)
);
  logic [N-1:0][BITS-1:0] A;
  logic [N-1:0][BITS-1:0] B;
  logic [LEN_W-1:0]       A_len;
  logic [LEN_W-1:0]       B_len;
  logic [BITS-1:0]        scalar;
  logic [2:0]             op_sel;
  logic                   scalar_sel;
  logic                   start;
  logic                   busy;
  logic                   done;
  logic [N-1:0][BITS-1:0] S;
  logic [LEN_W-1:0]       S_len;

  modport master (
    output A, A_len, B, B_len, scalar, op_sel, scalar_sel, start,
    input  busy, done, S, S_len
  );

  modport slave (
    input  A, A_len, B, B_len, scalar, op_sel, scalar_sel, start,
    output busy, done, S, S_len
  );
endinterface

// File: rtl/vector_stream_alu.sv
// Lane-parallel vector ALU: LANES elements per beat into a length-masked result register file.
// Define VECTOR_STREAM_ALU_SATURATE_EN to clamp add/sub/mult to the signed range instead of wrapping.
//
// state | meaning
// IDLE  | waiting for start; captures op, scalar and length
// CLEAR | zero all of S, load S_len, reset beat counter
// RUN   | one beat per cycle, LANES elements written per beat
// DONE  | one-cycle done pulse, then back to IDLE
module vector_stream_alu #(
  parameter int BITS       = 8,
  parameter int N          = 64,
  parameter int LANES      = 8,
  parameter int MULT_SHIFT = 0,
  parameter int LEN_W      = $clog2(N + 1)
) (
  input logic clk,
  input logic rst,
  vector_stream_alu_if.slave bus
);

  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int LL = $clog2(LANES);
  localparam int NB = N / LANES;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [2:0]             r_op;
  logic [BITS-1:0]        r_scalar;
  logic                   r_scalar_sel;
  logic [LEN_W-1:0]       r_len;
  logic [BW-1:0]          r_last_beat;
  logic [BW-1:0]          r_beat;
  logic [N-1:0][BITS-1:0] r_S;
  logic [LEN_W-1:0]       r_S_len;

  logic [LEN_W-1:0]       w_len_raw;
  logic [LEN_W-1:0]       w_len;
  logic [AW-1:0]          w_idx [LANES];
  logic [BITS-1:0]        w_a   [LANES];
  logic [BITS-1:0]        w_b   [LANES];
  logic [BITS-1:0]        w_res [LANES];

  function automatic logic [BITS-1:0] f_alu(input logic [2:0] op,
                                            input logic [BITS-1:0] a,
                                            input logic [BITS-1:0] b);
    logic signed [2*BITS-1:0] prod;
    logic [BITS-1:0]          res;
`ifdef VECTOR_STREAM_ALU_SATURATE_EN
    logic signed [BITS:0]     sum;
    logic signed [BITS:0]     dif;
    logic signed [2*BITS-1:0] prod_sh;
    logic [BITS-1:0]          vmax;
    logic [BITS-1:0]          vmin;
    vmax    = {1'b0, {(BITS-1){1'b1}}};
    vmin    = {1'b1, {(BITS-1){1'b0}}};
    sum     = $signed({a[BITS-1], a}) + $signed({b[BITS-1], b});
    dif     = $signed({a[BITS-1], a}) - $signed({b[BITS-1], b});
`endif
    prod = $signed({{BITS{a[BITS-1]}}, a}) * $signed({{BITS{b[BITS-1]}}, b});
    res  = '0;
    case (op)
`ifdef VECTOR_STREAM_ALU_SATURATE_EN
      // Overflow shows as the extra sign bit disagreeing with the result sign.
      3'b000: res = (sum[BITS] != sum[BITS-1]) ? (sum[BITS] ? vmin : vmax) : sum[BITS-1:0];
      3'b001: res = (dif[BITS] != dif[BITS-1]) ? (dif[BITS] ? vmin : vmax) : dif[BITS-1:0];
      3'b010: begin
        prod_sh = prod >>> MULT_SHIFT;
        if ((&prod_sh[2*BITS-1:BITS-1]) || !(|prod_sh[2*BITS-1:BITS-1]))
          res = prod_sh[BITS-1:0];
        else
          res = prod_sh[2*BITS-1] ? vmin : vmax;
      end
`else
      3'b000: res = a + b;
      3'b001: res = a - b;
      3'b010: res = BITS'(prod >>> MULT_SHIFT);
`endif
      3'b011: begin
        if ($signed(a) > $signed(b))       res = BITS'(1);
        else if ($signed(a) == $signed(b)) res = '0;
        else                               res = '1;
      end
      3'b100: res = a & b;
      3'b101: res = a | b;
      3'b110: res = a ^ b;
      3'b111: res = ~a;
      default: res = '0;
    endcase
    return res;
  endfunction

  always_comb begin
    w_len_raw = bus.scalar_sel ? bus.A_len
                               : ((bus.A_len > bus.B_len) ? bus.A_len : bus.B_len);
    w_len     = (w_len_raw > LEN_W'(N)) ? LEN_W'(N) : w_len_raw;
  end

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      w_idx[j] = (AW'(r_beat) << LL) + AW'(j);
      w_a[j]   = bus.A[w_idx[j]];
      w_b[j]   = r_scalar_sel ? r_scalar : bus.B[w_idx[j]];
      w_res[j] = (LEN_W'(w_idx[j]) < r_len) ? f_alu(r_op, w_a[j], w_b[j]) : '0;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_CLEAR;
      S_CLEAR: w_next = (r_len != '0) ? S_RUN : S_DONE;
      S_RUN:   if (r_beat == r_last_beat) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op         <= '0;
      r_scalar     <= '0;
      r_scalar_sel <= 1'b0;
      r_len        <= '0;
      r_last_beat  <= '0;
      r_beat       <= '0;
      r_S          <= '0;
      r_S_len      <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_op         <= bus.op_sel;
          r_scalar     <= bus.scalar;
          r_scalar_sel <= bus.scalar_sel;
          r_len        <= w_len;
          // Last beat index is ceil(L/LANES)-1; unused when L is zero.
          r_last_beat  <= BW'((w_len - LEN_W'(1)) >> LL);
        end
        S_CLEAR: begin
          r_S     <= '0;
          r_S_len <= r_len;
          r_beat  <= '0;
        end
        S_RUN: begin
          for (int j = 0; j < LANES; j++) r_S[w_idx[j]] <= w_res[j];
          r_beat <= r_beat + BW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.S     = r_S;
  assign bus.S_len = r_S_len;
  assign bus.busy  = (r_state == S_CLEAR) || (r_state == S_RUN);
  assign bus.done  = (r_state == S_DONE);

endmodule
